// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//
// Receive half of the UART. Recovers 8-bit frames (1 start bit, 8 data bits
// LSB first, optional parity bit, 1 stop bit) from an asynchronous serial
// line. It derives its own oversample tick from clk and samples each bit in
// the middle. The received byte is held until the consumer acknowledges it
// with rd.
//
// Build option:
//   UART_RX_PARITY_EN  When defined, a parity bit follows the data bits and is
//                      checked against p_sel (0 = even, 1 = odd). When
//                      undefined, frames are 8N1, p_sel is ignored and
//                      parity_err is tied low.
//
// Parameters:
//   CLK_FREQ    input clock frequency in Hz
//   OVERSAMPLE  oversample ticks per bit; the mid-bit sample is taken on
//               tick OVERSAMPLE/2
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset       asynchronous, active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   baud_sel    00 = 9600, 01 = 19200, 10 = 57600, 11 = 115200 baud
//   p_sel       parity select, 0 = even, 1 = odd
//   rd          consumer acknowledge, clears d_valid and overrun
//   d_out       last received byte
//   d_valid     high from frame completion until rd
//   busy        high while a frame is being received
//   frame_err   stop bit of the last frame was sampled low
//   parity_err  parity mismatch in the last frame
//   overrun     sticky, a frame completed while d_valid was still high
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [1:0] baud_sel,
    input  logic       p_sel,
    input  logic       rd,
    output logic [7:0] d_out,
    output logic       d_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    // Clocks per oversample tick for each rate, truncated toward zero.
    localparam int DIV_9600   = CLK_FREQ / (9600 * OVERSAMPLE);
    localparam int DIV_19200  = CLK_FREQ / (19200 * OVERSAMPLE);
    localparam int DIV_57600  = CLK_FREQ / (57600 * OVERSAMPLE);
    localparam int DIV_115200 = CLK_FREQ / (115200 * OVERSAMPLE);

    // The slowest rate needs the widest divider counter.
    localparam int DIV_W  = $clog2(DIV_9600 + 1);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int HALF   = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               rx_meta;
    logic               rx_sync;
    logic               armed;
    logic [1:0]         baud_lat;
    logic [DIV_W-1:0]   div_limit;
    logic [DIV_W-1:0]   div_cnt;
    logic [TICK_W-1:0]  tick_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift_reg;

    logic               tick;
    logic               sample;
    logic               last_bit;
    logic               start_det;
    logic               complete;

    // Two-flop synchronizer for the asynchronous serial line. Both flops
    // reset to the idle level so that reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // A start bit is only accepted after the line has been seen idle high
    // while waiting. This keeps a held-low line (break) from being taken as
    // a stream of back-to-back frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b0;
        end else if (start_det) begin
            armed <= 1'b0;
        end else if (state == IDLE && rx_sync) begin
            armed <= 1'b1;
        end
    end

    // The rate is captured at start detect so a change of baud_sel in the
    // middle of a frame cannot disturb the bit timing of that frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_lat <= 2'b00;
        end else if (start_det) begin
            baud_lat <= baud_sel;
        end
    end

    // Terminal count of the tick divider for the latched rate.
    always_comb begin
        div_limit = DIV_W'(DIV_115200 - 1);
        case (baud_lat)
            2'b00: div_limit = DIV_W'(DIV_9600 - 1);
            2'b01: div_limit = DIV_W'(DIV_19200 - 1);
            2'b10: div_limit = DIV_W'(DIV_57600 - 1);
            2'b11: div_limit = DIV_W'(DIV_115200 - 1);
        endcase
    end

    // The divider and tick counter are held at zero while idle, so every
    // frame is timed from the cycle its start edge was detected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (state == IDLE || div_cnt == div_limit) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick     = (state != IDLE) && (div_cnt == div_limit);
    assign sample   = tick && (tick_cnt == TICK_W'(HALF - 1));
    assign last_bit = (bit_cnt == 3'd7);

    // Oversample tick counter, one full wrap per bit period. The bit is
    // sampled when the middle tick of the period arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
        end else if (tick) begin
            if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Data bit index within the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= 3'd0;
        end else if (state == IDLE) begin
            bit_cnt <= 3'd0;
        end else if (state == DATA && sample) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Data arrives LSB first, so each new bit enters at the top and the
    // first bit ends up in bit 0 after eight shifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= 8'h00;
        end else if (state == DATA && sample) begin
            shift_reg <= {rx_sync, shift_reg[7:1]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The frame completes at the middle of the stop bit,
    // leaving half a bit of idle time to catch the next start edge.
    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !rx_sync) begin
                    start_det  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                // A start bit that is high again by mid-bit was a glitch.
                if (sample) begin
                    state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample && last_bit) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Result registers. If an acknowledge lands in the same cycle as a
    // completion, the new byte wins and nothing was lost, so overrun stays
    // clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out     <= 8'h00;
            d_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (complete) begin
            d_out     <= shift_reg;
            d_valid   <= 1'b1;
            frame_err <= ~rx_sync;
            if (d_valid && !rd) begin
                overrun <= 1'b1;
            end else if (rd) begin
                overrun <= 1'b0;
            end
        end else if (rd) begin
            d_valid <= 1'b0;
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic psel_lat;
    logic par_mismatch;

    // Parity sense is captured at start detect like the rate. The received
    // parity bit together with the data must have an even number of ones
    // for even parity and an odd number for odd parity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psel_lat     <= 1'b0;
            par_mismatch <= 1'b0;
        end else begin
            if (start_det) begin
                psel_lat <= p_sel;
            end
            if (state == PARITY && sample) begin
                par_mismatch <= (^shift_reg) ^ rx_sync ^ psel_lat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err <= 1'b0;
        end else if (complete) begin
            parity_err <= par_mismatch;
        end
    end
`else
    logic unused_psel;

    // Without a parity bit the parity select has no meaning.
    assign unused_psel = p_sel;
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//
// Self-checking bench for uart_rx. A behavioural transmitter drives frames
// onto rx and a reference model tracks what the receiver should report:
// last byte, valid/overrun bookkeeping and the error flags of the latest
// frame. A 20 MHz clock frequency is used so that bit periods are short
// and the truncated divider values (130/65/21/10) differ from the exact
// ratios.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CLK_FREQ   = 20_000_000;
    localparam int OVERSAMPLE = 16;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [1:0] baud_sel;
    logic       p_sel;
    logic       rd;
    logic [7:0] d_out;
    logic       d_valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int checks = 0;
    int passed = 0;

    // Reference model state.
    logic [7:0] exp_dout  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_fe    = 1'b0;
    logic       exp_pe    = 1'b0;
    logic       exp_ovr   = 1'b0;

    logic       busy_mid;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .baud_sel   (baud_sel),
        .p_sel      (p_sel),
        .rd         (rd),
        .d_out      (d_out),
        .d_valid    (d_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Clocks per bit: truncated clocks-per-tick times ticks per bit.
    function automatic int bit_clocks(input logic [1:0] b);
        int rate;
        case (b)
            2'b00:   rate = 9600;
            2'b01:   rate = 19200;
            2'b10:   rate = 57600;
            default: rate = 115200;
        endcase
        return (CLK_FREQ / (rate * OVERSAMPLE)) * OVERSAMPLE;
    endfunction

    // Consumer acknowledge; the model forgets the pending byte.
    task automatic pulse_rd();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    // Transmits one frame and updates the model. baud_sel and p_sel are
    // scrambled once the start bit is on the line, which must not matter.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] b,
                              input logic psel, input logic stop_bit,
                              input logic flip_par, output logic bmid);
        int   bc;
        int   ones;
        logic pbit;
        bc   = bit_clocks(b);
        ones = $countones(data);
        if (psel) begin
            pbit = ((ones % 2) == 0);
        end else begin
            pbit = ((ones % 2) == 1);
        end
        pbit = pbit ^ flip_par;
        bmid = 1'b0;
        baud_sel = b;
        p_sel    = psel;
        @(negedge clk);
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        baud_sel = 2'($urandom_range(0, 3));
        p_sel    = ~psel;
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (bc / 2) @(negedge clk);
            if (i == 0) bmid = busy;
            repeat (bc - bc / 2) @(negedge clk);
        end
        if (PAR_ON) begin
            rx = pbit;
            repeat (bc) @(negedge clk);
        end
        rx = stop_bit;
        repeat (bc) @(negedge clk);
        rx = 1'b1;
        if (exp_valid) exp_ovr = 1'b1;
        exp_valid = 1'b1;
        exp_dout  = data;
        exp_fe    = ~stop_bit;
        exp_pe    = PAR_ON && ((((ones + int'(pbit)) % 2) == 1) != psel);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx = 1'b1;
        baud_sel = 2'b11;
        p_sel = 1'b0;
        rd = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (d_out !== 8'h00) $display("[TB] FAIL reset_dout: got %0h expected 0", d_out); else passed++;
        checks++; if (d_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", d_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL reset_fe: got %b expected 0", frame_err); else passed++;
        checks++; if (parity_err !== 1'b0) $display("[TB] FAIL reset_pe: got %b expected 0", parity_err); else passed++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL reset_ovr: got %b expected 0", overrun); else passed++;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL idle_busy: got %b expected 0", busy); else passed++;
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 2'b11, 1'b0, 1'b1, 1'b0, busy_mid);
        checks++; if (busy_mid !== 1'b1) $display("[TB] FAIL basic_busy_mid: got %b expected 1", busy_mid); else passed++;
        checks++; if (d_out !== exp_dout) $display("[TB] FAIL basic_dout: got %0h expected %0h", d_out, exp_dout); else passed++;
        checks++; if (d_valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b expected 1", d_valid); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL basic_fe: got %b expected 0", frame_err); else passed++;
        checks++; if (parity_err !== exp_pe) $display("[TB] FAIL basic_pe: got %b expected %b", parity_err, exp_pe); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_end: got %b expected 0", busy); else passed++;
        pulse_rd();
        checks++; if (d_valid !== 1'b0) $display("[TB] FAIL basic_rd_valid: got %b expected 0", d_valid); else passed++;
    endtask

    task automatic test_parity();
        send_frame(8'h37, 2'b11, 1'b0, 1'b1, 1'b0, busy_mid);
        checks++; if (d_out !== 8'h37) $display("[TB] FAIL par_good_dout: got %0h expected 37", d_out); else passed++;
        checks++; if (parity_err !== exp_pe) $display("[TB] FAIL par_even_good: got %b expected %b", parity_err, exp_pe); else passed++;
        pulse_rd();
        send_frame(8'h37, 2'b11, 1'b0, 1'b1, 1'b1, busy_mid);
        checks++; if (parity_err !== exp_pe) $display("[TB] FAIL par_even_bad: got %b expected %b", parity_err, exp_pe); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL par_bad_fe: got %b expected 0", frame_err); else passed++;
        pulse_rd();
        send_frame(8'h37, 2'b11, 1'b1, 1'b1, 1'b0, busy_mid);
        checks++; if (parity_err !== exp_pe) $display("[TB] FAIL par_odd_good: got %b expected %b", parity_err, exp_pe); else passed++;
        pulse_rd();
    endtask

    task automatic test_frame_err();
        send_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, busy_mid);
        repeat (20) @(negedge clk);
        checks++; if (d_out !== 8'h55) $display("[TB] FAIL fe_dout: got %0h expected 55", d_out); else passed++;
        checks++; if (d_valid !== 1'b1) $display("[TB] FAIL fe_valid: got %b expected 1", d_valid); else passed++;
        checks++; if (frame_err !== 1'b1) $display("[TB] FAIL fe_flag: got %b expected 1", frame_err); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL fe_busy: got %b expected 0", busy); else passed++;
        pulse_rd();
    endtask

    task automatic test_glitch();
        int bc;
        bc = bit_clocks(2'b11);
        baud_sel = 2'b11;
        repeat (bc) @(negedge clk);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL glitch_busy: got %b expected 1", busy); else passed++;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (2 * bc) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL glitch_idle: got %b expected 0", busy); else passed++;
        checks++; if (d_valid !== 1'b0) $display("[TB] FAIL glitch_valid: got %b expected 0", d_valid); else passed++;
        checks++; if (frame_err !== exp_fe) $display("[TB] FAIL glitch_fe: got %b expected %b", frame_err, exp_fe); else passed++;
        checks++; if (parity_err !== exp_pe) $display("[TB] FAIL glitch_pe: got %b expected %b", parity_err, exp_pe); else passed++;
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 2'b11, 1'b0, 1'b1, 1'b0, busy_mid);
        send_frame(8'h22, 2'b11, 1'b0, 1'b1, 1'b0, busy_mid);
        checks++; if (d_out !== 8'h22) $display("[TB] FAIL b2b_dout: got %0h expected 22", d_out); else passed++;
        checks++; if (d_valid !== 1'b1) $display("[TB] FAIL b2b_valid: got %b expected 1", d_valid); else passed++;
        checks++; if (overrun !== exp_ovr) $display("[TB] FAIL b2b_ovr: got %b expected %b", overrun, exp_ovr); else passed++;
        pulse_rd();
        checks++; if (d_valid !== 1'b0) $display("[TB] FAIL b2b_rd_valid: got %b expected 0", d_valid); else passed++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL b2b_rd_ovr: got %b expected 0", overrun); else passed++;
    endtask

    task automatic test_break();
        int bc;
        bc = bit_clocks(2'b11);
        baud_sel = 2'b11;
        p_sel = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (14 * bc) @(negedge clk);
        exp_valid = 1'b1;
        exp_dout  = 8'h00;
        exp_fe    = 1'b1;
        exp_pe    = 1'b0;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL brk_busy_low: got %b expected 0", busy); else passed++;
        checks++; if (d_out !== exp_dout) $display("[TB] FAIL brk_dout: got %0h expected %0h", d_out, exp_dout); else passed++;
        checks++; if (frame_err !== 1'b1) $display("[TB] FAIL brk_fe: got %b expected 1", frame_err); else passed++;
        checks++; if (parity_err !== exp_pe) $display("[TB] FAIL brk_pe: got %b expected %b", parity_err, exp_pe); else passed++;
        rx = 1'b1;
        repeat (3 * bc) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL brk_busy_high: got %b expected 0", busy); else passed++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL brk_ovr: got %b expected 0", overrun); else passed++;
        pulse_rd();
    endtask

    task automatic test_baud_rates();
        send_frame(8'h6C, 2'b10, 1'b0, 1'b1, 1'b0, busy_mid);
        checks++; if (d_out !== 8'h6C) $display("[TB] FAIL baud57600_dout: got %0h expected 6c", d_out); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL baud57600_fe: got %b expected 0", frame_err); else passed++;
        pulse_rd();
        send_frame(8'h93, 2'b01, 1'b1, 1'b1, 1'b0, busy_mid);
        checks++; if (d_out !== 8'h93) $display("[TB] FAIL baud19200_dout: got %0h expected 93", d_out); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL baud19200_fe: got %b expected 0", frame_err); else passed++;
        checks++; if (parity_err !== exp_pe) $display("[TB] FAIL baud19200_pe: got %b expected %b", parity_err, exp_pe); else passed++;
        pulse_rd();
    endtask

    task automatic test_random();
        logic [7:0] data;
        logic [1:0] b;
        logic       psel;
        logic       stop_bit;
        logic       flip;
        for (int n = 0; n < 10; n++) begin
            data     = 8'($urandom);
            b        = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
            psel     = 1'($urandom_range(0, 1));
            stop_bit = ($urandom_range(0, 5) != 0);
            flip     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) pulse_rd();
            repeat ($urandom_range(10, 30)) @(negedge clk);
            send_frame(data, b, psel, stop_bit, flip, busy_mid);
            checks++; if (d_out !== exp_dout) $display("[TB] FAIL rnd%0d_dout: got %0h expected %0h", n, d_out, exp_dout); else passed++;
            checks++; if (d_valid !== exp_valid) $display("[TB] FAIL rnd%0d_valid: got %b expected %b", n, d_valid, exp_valid); else passed++;
            checks++; if (frame_err !== exp_fe) $display("[TB] FAIL rnd%0d_fe: got %b expected %b", n, frame_err, exp_fe); else passed++;
            checks++; if (parity_err !== exp_pe) $display("[TB] FAIL rnd%0d_pe: got %b expected %b", n, parity_err, exp_pe); else passed++;
            checks++; if (overrun !== exp_ovr) $display("[TB] FAIL rnd%0d_ovr: got %b expected %b", n, overrun, exp_ovr); else passed++;
            checks++; if (busy !== 1'b0) $display("[TB] FAIL rnd%0d_busy: got %b expected 0", n, busy); else passed++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int bc;
        logic [7:0] partial;
        bc = bit_clocks(2'b11);
        partial = 8'hA6;
        send_frame(8'h5A, 2'b11, 1'b0, 1'b1, 1'b0, busy_mid);
        repeat (10) @(negedge clk);
        baud_sel = 2'b11;
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            repeat (bc) @(negedge clk);
        end
        checks++; if (busy !== 1'b1) $display("[TB] FAIL rstmid_busy_before: got %b expected 1", busy); else passed++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); else passed++;
        checks++; if (d_valid !== 1'b0) $display("[TB] FAIL rstmid_valid: got %b expected 0", d_valid); else passed++;
        checks++; if (d_out !== 8'h00) $display("[TB] FAIL rstmid_dout: got %0h expected 0", d_out); else passed++;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        exp_dout  = 8'h00;
        exp_valid = 1'b0;
        exp_fe    = 1'b0;
        exp_pe    = 1'b0;
        exp_ovr   = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'hC3, 2'b11, 1'b0, 1'b1, 1'b0, busy_mid);
        checks++; if (d_out !== 8'hC3) $display("[TB] FAIL rstmid_c3_dout: got %0h expected c3", d_out); else passed++;
        checks++; if (d_valid !== 1'b1) $display("[TB] FAIL rstmid_c3_valid: got %b expected 1", d_valid); else passed++;
        checks++; if (frame_err !== 1'b0) $display("[TB] FAIL rstmid_c3_fe: got %b expected 0", frame_err); else passed++;
        checks++; if (parity_err !== 1'b0) $display("[TB] FAIL rstmid_c3_pe: got %b expected 0", parity_err); else passed++;
        checks++; if (overrun !== 1'b0) $display("[TB] FAIL rstmid_c3_ovr: got %b expected 0", overrun); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_break();
        test_baud_rates();
        test_random();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
